line_draw_engine: RTL

- Bresenham line rasteriser that sits directly downstream of enhanced_proc in the line-drawing system.
- The processor writes endpoint coordinates and a colour into memory-mapped registers, then writes a GO command.
- The engine walks the line and emits one pixel per accepted handshake toward the framebuffer/VGA adapter.
- Status is returned to the processor through o_Busy and o_Done.

---
 rtl/line_draw_engine.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/line_draw_engine.sv
// Bresenham line rasteriser: memory-mapped endpoint/colour registers, GO command,
// one pixel per accepted o_Plot/i_Ready handshake, Busy/Done status back to the processor.
module line_draw_engine #(
  parameter int unsigned X_WIDTH     = 9,
  parameter int unsigned Y_WIDTH     = 8,
  parameter int unsigned COLOR_WIDTH = 3
) (
  input  logic                   i_Clock,
  input  logic                   i_Resetn,
  input  logic                   i_Wr,
  input  logic [2:0]             i_Addr,
  input  logic [15:0]            i_WrData,
  input  logic                   i_Ready,
  output logic [X_WIDTH-1:0]     o_X,
  output logic [Y_WIDTH-1:0]     o_Y,
  output logic [COLOR_WIDTH-1:0] o_Color,
  output logic                   o_Plot,
  output logic                   o_Busy,
  output logic                   o_Done
);

  // Internal coordinate width must hold either axis once x/y are swapped for steep lines.
  localparam int unsigned CW = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
  localparam int unsigned EW = CW + 2;

  typedef enum logic [2:0] {StIdle, StSetup, StInit, StDraw, StDone} state_e;

  state_e                 r_state;

  logic [X_WIDTH-1:0]     r_x0, r_x1;
  logic [Y_WIDTH-1:0]     r_y0, r_y1;
  logic [COLOR_WIDTH-1:0] r_color;

  logic [X_WIDTH-1:0]     r_sx0, r_sx1;
  logic [Y_WIDTH-1:0]     r_sy0, r_sy1;
  logic [COLOR_WIDTH-1:0] r_scolor;

  logic                   r_steep;
  logic [CW-1:0]          r_ax, r_ay, r_bx, r_by;
  logic [CW-1:0]          r_cur_x, r_cur_y;
  logic signed [EW-1:0]   r_dx, r_dy, r_err;
  logic                   r_ystep_neg;

  logic                   w_go;
  logic [CW-1:0]          w_x0, w_y0, w_x1, w_y1;
  logic [CW-1:0]          w_adx, w_ady;
  logic                   w_steep;
  logic [CW-1:0]          w_px0, w_py0, w_px1, w_py1;
  logic                   w_swap;
  logic [CW-1:0]          w_dx, w_dy;
  logic signed [EW-1:0]   w_err_add, w_nerr;
  logic                   w_step;
  logic [CW-1:0]          w_nx, w_ny;
  logic                   w_unused_wdata;

  assign w_unused_wdata = ^i_WrData;
  assign w_go = i_Wr && (i_Addr == 3'd5) && (r_state == StIdle);

  // Register file: always writable, even mid-line; the line runs from snapshots.
  always_ff @(posedge i_Clock or negedge i_Resetn) begin
    if (!i_Resetn) begin
      r_x0    <= '0;
      r_y0    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_color <= '0;
    end else if (i_Wr) begin
      case (i_Addr)
        3'd0:    r_x0    <= i_WrData[X_WIDTH-1:0];
        3'd1:    r_y0    <= i_WrData[Y_WIDTH-1:0];
        3'd2:    r_x1    <= i_WrData[X_WIDTH-1:0];
        3'd3:    r_y1    <= i_WrData[Y_WIDTH-1:0];
        3'd4:    r_color <= i_WrData[COLOR_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Setup: steepness test, axis swap, then order endpoints by ascending x.
  always_comb begin
    w_x0    = CW'(r_sx0);
    w_y0    = CW'(r_sy0);
    w_x1    = CW'(r_sx1);
    w_y1    = CW'(r_sy1);
    w_adx   = (w_x1 >= w_x0) ? (w_x1 - w_x0) : (w_x0 - w_x1);
    w_ady   = (w_y1 >= w_y0) ? (w_y1 - w_y0) : (w_y0 - w_y1);
    w_steep = w_ady > w_adx;
    w_px0   = w_steep ? w_y0 : w_x0;
    w_py0   = w_steep ? w_x0 : w_y0;
    w_px1   = w_steep ? w_y1 : w_x1;
    w_py1   = w_steep ? w_x1 : w_y1;
    w_swap  = w_px0 > w_px1;
  end

  always_comb begin
    w_dx      = r_bx - r_ax;
    w_dy      = (r_by >= r_ay) ? (r_by - r_ay) : (r_ay - r_by);
    w_err_add = r_err + r_dy;
    w_step    = (w_err_add >= 0);
    w_nerr    = w_step ? (w_err_add - r_dx) : w_err_add;
    w_nx      = r_cur_x + CW'(1);
    w_ny      = r_cur_y;
    if (w_step) begin
      w_ny = r_ystep_neg ? (r_cur_y - CW'(1)) : (r_cur_y + CW'(1));
    end
  end

  always_ff @(posedge i_Clock or negedge i_Resetn) begin
    if (!i_Resetn) begin
      r_state     <= StIdle;
      r_sx0       <= '0;
      r_sy0       <= '0;
      r_sx1       <= '0;
      r_sy1       <= '0;
      r_scolor    <= '0;
      r_steep     <= 1'b0;
      r_ax        <= '0;
      r_ay        <= '0;
      r_bx        <= '0;
      r_by        <= '0;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_err       <= '0;
      r_ystep_neg <= 1'b0;
      o_X         <= '0;
      o_Y         <= '0;
      o_Color     <= '0;
      o_Plot      <= 1'b0;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_go) begin
            r_sx0    <= r_x0;
            r_sy0    <= r_y0;
            r_sx1    <= r_x1;
            r_sy1    <= r_y1;
            r_scolor <= r_color;
            o_Busy   <= 1'b1;
            r_state  <= StSetup;
          end
        end
        StSetup: begin
          r_steep <= w_steep;
          r_ax    <= w_swap ? w_px1 : w_px0;
          r_ay    <= w_swap ? w_py1 : w_py0;
          r_bx    <= w_swap ? w_px0 : w_px1;
          r_by    <= w_swap ? w_py0 : w_py1;
          r_state <= StInit;
        end
        StInit: begin
          r_dx        <= $signed(EW'(w_dx));
          r_dy        <= $signed(EW'(w_dy));
          r_err       <= -$signed(EW'(w_dx >> 1));
          r_ystep_neg <= r_ay > r_by;
          r_cur_x     <= r_ax;
          r_cur_y     <= r_ay;
          // Present the first pixel as DRAW is entered.
          o_X         <= r_steep ? X_WIDTH'(r_ay) : X_WIDTH'(r_ax);
          o_Y         <= r_steep ? Y_WIDTH'(r_ax) : Y_WIDTH'(r_ay);
          o_Color     <= r_scolor;
          o_Plot      <= 1'b1;
          r_state     <= StDraw;
        end
        StDraw: begin
          if (i_Ready) begin
            if (r_cur_x == r_bx) begin
              o_Plot  <= 1'b0;
              o_Done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_cur_x <= w_nx;
              r_cur_y <= w_ny;
              r_err   <= w_nerr;
              o_X     <= r_steep ? X_WIDTH'(w_ny) : X_WIDTH'(w_nx);
              o_Y     <= r_steep ? Y_WIDTH'(w_nx) : Y_WIDTH'(w_ny);
            end
          end
        end
        StDone: begin
          o_Done  <= 1'b0;
          o_Busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          o_Plot  <= 1'b0;
          o_Done  <= 1'b0;
          o_Busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule
